// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: two-stage immediate generator with optional PC-relative target.
// Stage 1 decodes the immediate. Stage 2 forms pc + imm. Both sides use valid/ready.
module imm_gen_pipe #(
  parameter int Reg_size = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_in_valid,
  output logic                o_in_ready,
  input  logic [2:0]          i_im_type,
  input  logic [24:0]         i_instr,
  input  logic [Reg_size-1:0] i_pc,
  input  logic                i_use_pc,
  output logic                o_out_valid,
  input  logic                i_out_ready,
  output logic [Reg_size-1:0] o_imm_out,
  output logic [Reg_size-1:0] o_target_out,
  output logic                o_err_out
);

  typedef enum logic [2:0] {
    IM_I = 3'd0, IM_S = 3'd1, IM_B = 3'd2, IM_U = 3'd3,
    IM_J = 3'd4, IM_Z = 3'd5, IM_SH = 3'd6, IM_ILL = 3'd7
  } im_type_e;

  // vld_pipe[1] = stage 1 full, vld_pipe[2] = stage 2 full
  logic [2:1]          r_vld_pipe;
  logic [Reg_size-1:0] r_s1_imm, r_s1_pc;
  logic                r_s1_use_pc, r_s1_err;
  logic [Reg_size-1:0] r_s2_imm, r_s2_tgt;
  logic                r_s2_err;

  logic                w_s2_accept, w_s1_adv, w_in_fire;
  logic [31:0]         w_imm32;
  logic                w_sext, w_err;
  logic [Reg_size-1:0] w_imm;

  assign w_s2_accept = !r_vld_pipe[2] || i_out_ready;
  assign w_s1_adv    = r_vld_pipe[1] && w_s2_accept;
  assign o_in_ready  = !r_vld_pipe[1] || w_s2_accept;
  assign w_in_fire   = i_in_valid && o_in_ready;

  // Format decode: build the 32-bit immediate, then widen signed or unsigned.
  always_comb begin
    w_imm32 = '0;
    w_sext  = 1'b1;
    w_err   = 1'b0;
    case (im_type_e'(i_im_type))
      IM_I: w_imm32 = {{20{i_instr[24]}}, i_instr[24:13]};
      IM_S: w_imm32 = {{20{i_instr[24]}}, i_instr[24:18], i_instr[4:0]};
      IM_B: w_imm32 = {{19{i_instr[24]}}, i_instr[24], i_instr[0], i_instr[23:18],
                       i_instr[4:1], 1'b0};
      IM_U: w_imm32 = {i_instr[24:5], 12'b0};
      IM_J: w_imm32 = {{11{i_instr[24]}}, i_instr[24], i_instr[12:5], i_instr[13],
                       i_instr[23:14], 1'b0};
      IM_Z: begin
        w_imm32 = {27'b0, i_instr[12:8]};
        w_sext  = 1'b0;
      end
      IM_SH: begin
        // RV64 shifts need a 6-bit shamt, RV32 only 5
        if (Reg_size == 64) w_imm32 = {26'b0, i_instr[18:13]};
        else                w_imm32 = {27'b0, i_instr[17:13]};
        w_sext = 1'b0;
      end
      default: begin
        w_imm32 = '0;
        w_sext  = 1'b0;
        w_err   = 1'b1;
      end
    endcase
    // On RV64 the signed formats (including U) copy bit 31 upward
    w_imm = w_sext ? Reg_size'($signed(w_imm32)) : Reg_size'(w_imm32);
  end

  // Stage 1: load a new request when it fires, otherwise empty on advance, else hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_pipe[1] <= 1'b0;
      r_s1_imm      <= '0;
      r_s1_pc       <= '0;
      r_s1_use_pc   <= 1'b0;
      r_s1_err      <= 1'b0;
    end else if (w_in_fire) begin
      r_vld_pipe[1] <= 1'b1;
      r_s1_imm      <= w_imm;
      r_s1_pc       <= i_pc;
      r_s1_use_pc   <= i_use_pc;
      r_s1_err      <= w_err;
    end else if (w_s1_adv) begin
      r_vld_pipe[1] <= 1'b0;
    end
  end

  // Stage 2: take stage 1 when it advances, otherwise empty on drain, else hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld_pipe[2] <= 1'b0;
      r_s2_imm      <= '0;
      r_s2_tgt      <= '0;
      r_s2_err      <= 1'b0;
    end else if (w_s1_adv) begin
      r_vld_pipe[2] <= 1'b1;
      r_s2_imm      <= r_s1_imm;
      r_s2_tgt      <= r_s1_use_pc ? (r_s1_pc + r_s1_imm) : '0;
      r_s2_err      <= r_s1_err;
    end else if (i_out_ready) begin
      r_vld_pipe[2] <= 1'b0;
    end
  end

  assign o_out_valid  = r_vld_pipe[2];
  assign o_imm_out    = r_s2_imm;
  assign o_target_out = r_s2_tgt;
  assign o_err_out    = r_s2_err;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one RV32 and one RV64 instance share the stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, use_pc;
  logic [2:0]  im_type;
  logic [24:0] instr;
  logic [31:0] pc;
  logic [63:0] pc64;
  logic        in_ready, out_valid, err_out;
  logic [31:0] imm_out, target_out;
  logic        in_ready64, out_valid64, err_out64;
  logic [63:0] imm_out64, target_out64;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  assign pc64 = {32'b0, pc};

  imm_gen_pipe #(.Reg_size(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_im_type(im_type), .i_instr(instr), .i_pc(pc), .i_use_pc(use_pc),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_imm_out(imm_out),
    .o_target_out(target_out), .o_err_out(err_out)
  );

  imm_gen_pipe #(.Reg_size(64)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .o_in_ready(in_ready64),
    .i_im_type(im_type), .i_instr(instr), .i_pc(pc64), .i_use_pc(use_pc),
    .o_out_valid(out_valid64), .i_out_ready(out_ready), .o_imm_out(imm_out64),
    .o_target_out(target_out64), .o_err_out(err_out64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one cycle; return at the following falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] t, input logic [24:0] ins,
                       input logic [31:0] p, input logic up);
    in_valid = 1'b1; im_type = t; instr = ins; pc = p; use_pc = up;
  endtask

  // Single request with out_ready high: accepted at the next edge, visible after the one after.
  task automatic single(input string tag, input logic [2:0] t, input logic [24:0] ins,
                        input logic [31:0] p, input logic up);
    drive(t, ins, p, up);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
  endtask

  int sent, got;
  logic saw_block;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; use_pc = 1'b0;
    im_type = 3'd0; instr = '0; pc = '0;
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_imm", 64'(imm_out), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // addi x1,x0,-1
    single("addi", 3'd0, 25'h1FFE001, 32'h0, 1'b0);
    chk("addi_imm", 64'(imm_out), 64'hFFFF_FFFF);
    chk("addi_err", 64'(err_out), 64'd0);
    chk("addi_tgt", 64'(target_out), 64'd0);
    chk("addi_imm64", imm_out64, 64'hFFFF_FFFF_FFFF_FFFF);

    // beq -4 at pc 0x100
    single("beq", 3'd2, 25'h1FC001D, 32'h100, 1'b1);
    chk("beq_imm", 64'(imm_out), 64'hFFFF_FFFC);
    chk("beq_tgt", 64'(target_out), 64'h0000_00FC);
    chk("beq_tgt64", target_out64, 64'h0000_0000_0000_00FC);

    // U with bit 31 set
    single("lui", 3'd3, 25'h1000000, 32'h0, 1'b0);
    chk("lui_imm64", imm_out64, 64'hFFFF_FFFF_8000_0000);
    chk("lui_imm32", 64'(imm_out), 64'h8000_0000);

    // jal +2048
    single("jal", 3'd4, 25'h0002000, 32'h0, 1'b0);
    chk("jal_imm", 64'(imm_out), 64'h0000_0800);

    // sw with offset -8: imm[11:5]=0x7F at instr[24:18], imm[4:0]=0x18 at instr[4:0]
    single("sw", 3'd1, 25'h1FC0018, 32'h0, 1'b0);
    chk("sw_imm", 64'(imm_out), 64'hFFFF_FFF8);

    // illegal format
    single("ill", 3'd7, 25'h1FFFFFF, 32'h40, 1'b0);
    chk("ill_imm", 64'(imm_out), 64'd0);
    chk("ill_err", 64'(err_out), 64'd1);

    // CSR zimm
    single("zimm", 3'd5, 25'h0001F00, 32'h0, 1'b0);
    chk("zimm_imm", 64'(imm_out), 64'h1F);
    chk("zimm_err", 64'(err_out), 64'd0);

    // shamt with instr[18:13]=0x3F: RV32 keeps 5 bits, RV64 keeps 6, never sign-extended
    single("sh", 3'd6, 25'h007E000, 32'h0, 1'b0);
    chk("sh_imm32", 64'(imm_out), 64'h1F);
    chk("sh_imm64", imm_out64, 64'h3F);
    tick();
    chk("idle_valid", 64'(out_valid), 64'd0);

    // Backpressure: five I-type requests (imm 1..5), out_ready low for cycles 2..5
    sent = 0; got = 0; saw_block = 1'b0;
    for (int c = 0; c < 14; c++) begin
      in_valid  = (sent < 5);
      im_type   = 3'd0;
      instr     = 25'((sent + 1) << 13);
      use_pc    = 1'b0;
      out_ready = !(c >= 2 && c < 6);
      #1;
      if (c >= 2 && c < 6) chk("bp_inready_stall", 64'(in_ready), 64'd0);
      if (c == 6) chk("bp_inready_release", 64'(in_ready), 64'd1);
      if (in_valid && !in_ready) saw_block = 1'b1;
      // head of the output must be the next in-order value, stalled or not
      if (out_valid) chk("bp_order", 64'(imm_out), 64'(got + 1));
      if (out_valid && out_ready) got++;
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(got), 64'd5);
    chk("bp_blocked", 64'(saw_block), 64'd1);
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Reset with both stages full
    out_ready = 1'b0;
    drive(3'd2, 25'h1FC001D, 32'h100, 1'b1);
    tick();
    drive(3'd0, 25'h1FFE001, 32'h200, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("full_inready", 64'(in_ready), 64'd0);
    chk("full_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_imm", 64'(imm_out), 64'd0);
    chk("arst_tgt", 64'(target_out), 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_ready", 64'(in_ready), 64'd1);
    single("post", 3'd0, 25'(7 << 13), 32'h0, 1'b0);
    chk("post_imm", 64'(imm_out), 64'd7);
    tick();
    chk("post_alone", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
